// File: rtl/hazard_stall_controller_if.sv
// Pipeline-side bundle for the hazard/stall controller: ID/EX hazard inputs,
// vector-unit handshake, and the stall/flush controls driven back to the pipeline.
interface hazard_stall_controller_if;
   logic [3:0]  id_rs1;
   logic [3:0]  id_rs2;
   logic        id_uses_rs2;
   logic [3:0]  ex_rd;
   logic        ex_MemRead;
   logic        ex_RegWrite;
   logic        id_vec_req;
   logic        vec_done;
   logic        branch_taken;
   logic        pc_en;
   logic        ifid_en;
   logic        ifid_flush;
   logic        idex_flush;
   logic        vec_go;
   logic        vec_timeout;
   logic [15:0] stall_cycles;
   logic [1:0]  state;

   modport master (
      output id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_MemRead, ex_RegWrite,
             id_vec_req, vec_done, branch_taken,
      input  pc_en, ifid_en, ifid_flush, idex_flush, vec_go, vec_timeout,
             stall_cycles, state
   );

   modport slave (
      input  id_rs1, id_rs2, id_uses_rs2, ex_rd, ex_MemRead, ex_RegWrite,
             id_vec_req, vec_done, branch_taken,
      output pc_en, ifid_en, ifid_flush, idex_flush, vec_go, vec_timeout,
             stall_cycles, state
   );
endinterface

// File: rtl/hazard_stall_controller.sv
// Load-use / vector-op stall and branch flush controller. Control outputs are
// Mealy (state + current inputs); state, wait counter and error flag are registered.
module hazard_stall_controller #(
   parameter int unsigned VEC_TIMEOUT = 255
) (
   input logic                      clk,
   input logic                      rst,
   hazard_stall_controller_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN        = 2'b00,
      ST_LOAD_STALL = 2'b01,
      ST_VEC_WAIT   = 2'b10,
      ST_RSVD       = 2'b11
   } state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(VEC_TIMEOUT - 32'd1);

   state_t      r_state;
   state_t      w_next_state;
   logic [7:0]  r_vec_cnt;
   logic [7:0]  w_vec_cnt_next;
   logic        r_vec_timeout;
   logic        w_timeout_set;
   logic [15:0] r_stall_cycles;
   logic        w_load_use;
   logic        w_pc_en;
   logic        w_ifid_en;
   logic        w_ifid_flush;
   logic        w_idex_flush;
   logic        w_vec_go;

   assign w_load_use = bus.ex_MemRead & bus.ex_RegWrite &
                       ((bus.ex_rd == bus.id_rs1) |
                        (bus.id_uses_rs2 & (bus.ex_rd == bus.id_rs2)));

   // Output decode and next-state selection; reset forces the idle RUN outputs.
   always_comb begin
      w_pc_en        = 1'b1;
      w_ifid_en      = 1'b1;
      w_ifid_flush   = 1'b0;
      w_idex_flush   = 1'b0;
      w_vec_go       = 1'b0;
      w_next_state   = ST_RUN;
      w_vec_cnt_next = r_vec_cnt;
      w_timeout_set  = 1'b0;
      if (rst) begin
         w_vec_cnt_next = 8'd0;
      end else begin
         case (r_state)
            ST_RUN: begin
               if (bus.branch_taken) begin
                  w_ifid_flush = 1'b1;
                  w_idex_flush = 1'b1;
               end else if (w_load_use) begin
                  w_pc_en      = 1'b0;
                  w_ifid_en    = 1'b0;
                  w_idex_flush = 1'b1;
                  w_next_state = ST_LOAD_STALL;
               end else if (bus.id_vec_req) begin
                  w_vec_go       = 1'b1;
                  w_pc_en        = 1'b0;
                  w_ifid_en      = 1'b0;
                  w_idex_flush   = 1'b1;
                  w_vec_cnt_next = 8'd0;
                  w_next_state   = ST_VEC_WAIT;
               end else begin
                  w_next_state = ST_RUN;
               end
            end
            ST_LOAD_STALL: begin
               // One bubble per load: the hazard compare is not re-evaluated here.
               if (bus.branch_taken) begin
                  w_ifid_flush = 1'b1;
                  w_idex_flush = 1'b1;
               end else begin
                  w_ifid_flush = 1'b0;
               end
            end
            ST_VEC_WAIT: begin
               if (bus.vec_done) begin
                  w_next_state = ST_RUN;
               end else if (r_vec_cnt == TIMEOUT_LAST) begin
                  w_timeout_set = 1'b1;
               end else begin
                  w_pc_en        = 1'b0;
                  w_ifid_en      = 1'b0;
                  w_idex_flush   = 1'b1;
                  w_vec_cnt_next = r_vec_cnt + 8'd1;
                  w_next_state   = ST_VEC_WAIT;
               end
            end
            default: begin
               w_next_state = ST_RUN;
            end
         endcase
      end
   end

   // State, vector wait counter, sticky timeout flag and saturating stall counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= ST_RUN;
         r_vec_cnt      <= 8'd0;
         r_vec_timeout  <= 1'b0;
         r_stall_cycles <= 16'd0;
      end else begin
         r_state   <= w_next_state;
         r_vec_cnt <= w_vec_cnt_next;
         if (w_timeout_set) begin
            r_vec_timeout <= 1'b1;
         end else begin
            r_vec_timeout <= r_vec_timeout;
         end
         if (!w_pc_en && (r_stall_cycles != 16'hFFFF)) begin
            r_stall_cycles <= r_stall_cycles + 16'd1;
         end else begin
            r_stall_cycles <= r_stall_cycles;
         end
      end
   end

   assign bus.pc_en        = w_pc_en;
   assign bus.ifid_en      = w_ifid_en;
   assign bus.ifid_flush   = w_ifid_flush;
   assign bus.idex_flush   = w_idex_flush;
   assign bus.vec_go       = w_vec_go;
   assign bus.vec_timeout  = r_vec_timeout;
   assign bus.stall_cycles = r_stall_cycles;
   assign bus.state        = r_state;
endmodule

// File: tb/tb_hazard_stall_controller.sv
// Self-checking bench for hazard_stall_controller: reset checks, a table of
// single-cycle RUN decisions, hand-written multi-cycle sequences, and random traffic.
module tb_hazard_stall_controller;
   localparam int unsigned TO = 8;

   logic clk = 1'b0;
   logic rst;
   int   n_tests = 0;
   int   n_fail  = 0;

   hazard_stall_controller_if bus();

   hazard_stall_controller #(.VEC_TIMEOUT(TO)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   // Reference model: mode 0 = running, 1 = after load bubble, 2 = waiting on vector unit
   int          m_mode;
   int          m_age;
   int          m_stalls;
   bit          m_err;
   logic [4:0]  last_outs;

   typedef struct {
      logic [3:0] rs1, rs2, rd;
      logic       uses2, mrd, rwr, vreq, vdone, br;
      logic [4:0] exp_outs;   // {pc_en, ifid_en, ifid_flush, idex_flush, vec_go}
      logic [1:0] exp_next;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic set_idle();
      bus.id_rs1 = 4'd1; bus.id_rs2 = 4'd2; bus.id_uses_rs2 = 1'b1;
      bus.ex_rd = 4'd9; bus.ex_MemRead = 1'b0; bus.ex_RegWrite = 1'b0;
      bus.id_vec_req = 1'b0; bus.vec_done = 1'b0; bus.branch_taken = 1'b0;
   endtask

   task automatic set_load_use();
      bus.ex_MemRead = 1'b1; bus.ex_RegWrite = 1'b1; bus.ex_rd = 4'd5; bus.id_rs1 = 4'd5;
   endtask

   task automatic model_reset();
      m_mode = 0; m_age = 0; m_stalls = 0; m_err = 1'b0;
   endtask

   function automatic logic [4:0] dut_outs();
      return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_flush, bus.vec_go};
   endfunction

   task automatic model_eval(output logic [4:0] o, output int nm, output int na, output bit se);
      bit lu;
      lu = bus.ex_MemRead && bus.ex_RegWrite &&
           ((bus.ex_rd == bus.id_rs1) || (bus.id_uses_rs2 && (bus.ex_rd == bus.id_rs2)));
      o = 5'b11000; nm = 0; na = m_age; se = 1'b0;
      if (m_mode == 2) begin
         if (bus.vec_done) begin
            nm = 0;
         end else if (m_age == int'(TO) - 1) begin
            se = 1'b1;
         end else begin
            o = 5'b00010; nm = 2; na = m_age + 1;
         end
      end else if (bus.branch_taken) begin
         o = 5'b11110;
      end else if (m_mode == 0 && lu) begin
         o = 5'b00010; nm = 1;
      end else if (m_mode == 0 && bus.id_vec_req) begin
         o = 5'b00011; nm = 2; na = 0;
      end
   endtask

   // Called at posedge+1 with inputs already driven; checks, then crosses one edge.
   task automatic do_cycle(input string name);
      logic [4:0] o;
      int         nm, na;
      bit         se;
      #2;
      model_eval(o, nm, na, se);
      last_outs = dut_outs();
      check(name, {8'd0, last_outs, bus.state, bus.stall_cycles, bus.vec_timeout},
                  {8'd0, o, 2'(m_mode), 16'(m_stalls), m_err});
      @(posedge clk);
      if (!o[4] && m_stalls < 65535) m_stalls++;
      m_mode = nm; m_age = na;
      if (se) m_err = 1'b1;
      #1;
   endtask

   task automatic pulse_reset();
      rst = 1'b1; #1; rst = 1'b0;
      model_reset(); set_idle();
   endtask

   vec_t tbl[12];
   int   go_cnt, stall_cnt;

   initial begin
      tbl[0]  = '{4'd5, 4'd2, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'b01};
      tbl[1]  = '{4'd3, 4'd5, 4'd5, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'b00};
      tbl[2]  = '{4'd3, 4'd5, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'b01};
      tbl[3]  = '{4'd5, 4'd2, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'b11000, 2'b00};
      tbl[4]  = '{4'd5, 4'd2, 4'd5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'b11000, 2'b00};
      tbl[5]  = '{4'd0, 4'd2, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'b01};
      tbl[6]  = '{4'd5, 4'd2, 4'd5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'b11110, 2'b00};
      tbl[7]  = '{4'd1, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'b00011, 2'b10};
      tbl[8]  = '{4'd5, 4'd2, 4'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'b00010, 2'b01};
      tbl[9]  = '{4'd1, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 5'b11110, 2'b00};
      tbl[10] = '{4'd1, 4'd2, 4'd9, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5'b11000, 2'b00};
      tbl[11] = '{4'd15, 4'd2, 4'd15, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'b00010, 2'b01};

      // Reset: hazardous inputs must be ignored while rst is high
      set_idle(); set_load_use(); bus.id_vec_req = 1'b1;
      rst = 1'b1;
      #3;
      check("reset_outs", 32'(dut_outs()), 32'(5'b11000));
      check("reset_regs", {13'd0, bus.state, bus.stall_cycles, bus.vec_timeout}, 32'd0);
      @(posedge clk); #1;
      check("reset_hold", {8'd0, dut_outs(), bus.state, bus.stall_cycles, bus.vec_timeout},
                          {8'd0, 5'b11000, 2'b00, 16'd0, 1'b0});
      rst = 1'b0; model_reset(); set_idle();

      // Single-cycle decisions from RUN
      for (int i = 0; i < 12; i++) begin
         bus.id_rs1 = tbl[i].rs1; bus.id_rs2 = tbl[i].rs2; bus.ex_rd = tbl[i].rd;
         bus.id_uses_rs2 = tbl[i].uses2; bus.ex_MemRead = tbl[i].mrd;
         bus.ex_RegWrite = tbl[i].rwr; bus.id_vec_req = tbl[i].vreq;
         bus.vec_done = tbl[i].vdone; bus.branch_taken = tbl[i].br;
         #2;
         check($sformatf("tbl%0d_outs", i), 32'(dut_outs()), 32'(tbl[i].exp_outs));
         @(posedge clk); #1;
         check($sformatf("tbl%0d_next", i), 32'(bus.state), 32'(tbl[i].exp_next));
         pulse_reset();
      end

      // Load-use: one bubble, then back to RUN with stall_cycles = 1
      set_load_use();
      do_cycle("ld_c1");
      do_cycle("ld_c2");
      check("ld_state", 32'(bus.state), 32'd0);
      check("ld_stalls", 32'(bus.stall_cycles), 32'd1);

      // Branch during the load bubble flushes both and returns to RUN
      pulse_reset(); set_load_use();
      do_cycle("ldbr_c1");
      bus.branch_taken = 1'b1;
      do_cycle("ldbr_c2");
      check("ldbr_outs", 32'(last_outs), 32'(5'b11110));
      check("ldbr_state", 32'(bus.state), 32'd0);

      // Vector op completes with vec_done four cycles after vec_go
      pulse_reset(); go_cnt = 0; stall_cnt = 0;
      for (int c = 0; c <= 4; c++) begin
         set_idle();
         bus.id_vec_req = (c == 0);
         bus.vec_done   = (c == 4);
         bus.branch_taken = (c == 2);
         do_cycle($sformatf("vec_c%0d", c));
         if (last_outs[0]) go_cnt++;
         if (!last_outs[4]) stall_cnt++;
         if (c == 2) check("vec_branch_ignored", 32'(last_outs), 32'(5'b00010));
         if (c < 4) check($sformatf("vec_state%0d", c), 32'(bus.state), 32'd2);
      end
      check("vec_go_pulses", go_cnt, 1);
      check("vec_stall_cnt", stall_cnt, 4);
      check("vec_state_end", 32'(bus.state), 32'd0);
      check("vec_stalls", 32'(bus.stall_cycles), 32'd4);

      // Timeout: no vec_done for TO cycles in VEC_WAIT
      pulse_reset(); stall_cnt = 0;
      bus.id_vec_req = 1'b1;
      do_cycle("to_req");
      if (!last_outs[4]) stall_cnt++;
      set_idle();
      for (int c = 0; c < int'(TO); c++) begin
         do_cycle($sformatf("to_w%0d", c));
         if (!last_outs[4]) stall_cnt++;
      end
      check("to_flag", 32'(bus.vec_timeout), 32'd1);
      check("to_state", 32'(bus.state), 32'd0);
      check("to_stall_cnt", stall_cnt, int'(TO));
      set_load_use();
      for (int c = 0; c < 4; c++) do_cycle($sformatf("to_after%0d", c));
      check("to_sticky", 32'(bus.vec_timeout), 32'd1);
      pulse_reset();
      check("to_cleared", 32'(bus.vec_timeout), 32'd0);

      // vec_done on the timeout cycle wins
      bus.id_vec_req = 1'b1;
      do_cycle("tie_req");
      set_idle();
      for (int c = 0; c < int'(TO); c++) begin
         bus.vec_done = (c == int'(TO) - 1);
         do_cycle($sformatf("tie_w%0d", c));
      end
      check("tie_no_flag", 32'(bus.vec_timeout), 32'd0);
      check("tie_state", 32'(bus.state), 32'd0);

      // Asynchronous reset mid-VEC_WAIT, between edges
      pulse_reset(); bus.id_vec_req = 1'b1;
      do_cycle("ar_req");
      set_idle();
      do_cycle("ar_w0");
      rst = 1'b1; #1;
      check("ar_regs", {13'd0, bus.state, bus.stall_cycles, bus.vec_timeout}, 32'd0);
      check("ar_outs", 32'(dut_outs()), 32'(5'b11000));
      rst = 1'b0; model_reset(); #1;
      check("ar_state_rel", 32'(bus.state), 32'd0);
      do_cycle("ar_post");
      check("ar_no_go", 32'(last_outs[0]), 32'd0);

      // Random traffic against the reference model
      pulse_reset();
      for (int c = 0; c < 3000; c++) begin
         bus.id_rs1 = 4'($urandom_range(0, 3));
         bus.id_rs2 = 4'($urandom_range(0, 3));
         bus.ex_rd  = 4'($urandom_range(0, 3));
         bus.id_uses_rs2  = 1'($urandom_range(0, 1));
         bus.ex_MemRead   = ($urandom_range(0, 99) < 50);
         bus.ex_RegWrite  = ($urandom_range(0, 99) < 60);
         bus.id_vec_req   = ($urandom_range(0, 99) < 20);
         bus.vec_done     = ($urandom_range(0, 99) < 12);
         bus.branch_taken = ($urandom_range(0, 99) < 15);
         do_cycle("rand");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
